// File: rtl/hazard_if.sv
// hazard_if: pipeline-side signals for the hazard controller; stat_* exist only with HAZ_STATS_EN
interface hazard_if;
  logic [4:0] id_ra;
  logic [4:0] id_rb;
  logic       id_usesA;
  logic       id_usesB;
  logic       id_div;
  logic [4:0] ex_ra;
  logic [4:0] ex_rb;
  logic [4:0] ex_rw;
  logic       ex_regWr;
  logic       ex_memtoreg;
  logic       branch_taken;
  logic [4:0] mem_rw;
  logic       mem_regWr;
  logic [4:0] wb_rw;
  logic       wb_regWr;
  logic       hazard;
  logic       BranchBubble;
  logic       ifid_flush;
  logic       pc_stall;
  logic       ifid_stall;
  logic       div_busy;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
`ifdef HAZ_STATS_EN
  logic [31:0] stat_stall;
  logic [31:0] stat_bubble;
  modport master (
    output id_ra, id_rb, id_usesA, id_usesB, id_div, ex_ra, ex_rb, ex_rw, ex_regWr,
           ex_memtoreg, branch_taken, mem_rw, mem_regWr, wb_rw, wb_regWr,
    input  hazard, BranchBubble, ifid_flush, pc_stall, ifid_stall, div_busy, fwdA, fwdB,
           stat_stall, stat_bubble
  );
  modport slave (
    input  id_ra, id_rb, id_usesA, id_usesB, id_div, ex_ra, ex_rb, ex_rw, ex_regWr,
           ex_memtoreg, branch_taken, mem_rw, mem_regWr, wb_rw, wb_regWr,
    output hazard, BranchBubble, ifid_flush, pc_stall, ifid_stall, div_busy, fwdA, fwdB,
           stat_stall, stat_bubble
  );
`else
  modport master (
    output id_ra, id_rb, id_usesA, id_usesB, id_div, ex_ra, ex_rb, ex_rw, ex_regWr,
           ex_memtoreg, branch_taken, mem_rw, mem_regWr, wb_rw, wb_regWr,
    input  hazard, BranchBubble, ifid_flush, pc_stall, ifid_stall, div_busy, fwdA, fwdB
  );
  modport slave (
    input  id_ra, id_rb, id_usesA, id_usesB, id_div, ex_ra, ex_rb, ex_rw, ex_regWr,
           ex_memtoreg, branch_taken, mem_rw, mem_regWr, wb_rw, wb_regWr,
    output hazard, BranchBubble, ifid_flush, pc_stall, ifid_stall, div_busy, fwdA, fwdB
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch-squash bubbles, divide hold and EX forwarding selects; HAZ_STATS_EN adds stall/bubble counters
module hazard_ctrl #(
  parameter int BRANCH_SLOTS = 1,
  parameter int DIV_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  hazard_if.slave hz
);
  typedef enum logic [1:0] {IDLE, BRFLUSH, DIVBUSY} state_t;
  localparam logic [4:0] BR_INIT  = (BRANCH_SLOTS > 1) ? 5'(BRANCH_SLOTS - 2) : 5'd0;
  localparam logic [4:0] DIV_INIT = 5'(DIV_CYCLES - 2);
  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       lu, busy, flush, stall;
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_rw,
                                         input logic m_we, input logic [4:0] w_rw,
                                         input logic w_we);
    return (m_we && m_rw != 5'd0 && m_rw == src) ? 2'b10 :
           (w_we && w_rw != 5'd0 && w_rw == src) ? 2'b01 : 2'b00;
  endfunction
  // Hazard terms; load-use only counts while idle so an active flush or divide masks it
  always_comb begin
    lu    = (state_q == IDLE) & hz.ex_memtoreg & hz.ex_regWr & (hz.ex_rw != 5'd0) &
            ((hz.id_usesA & (hz.ex_rw == hz.id_ra)) | (hz.id_usesB & (hz.ex_rw == hz.id_rb)));
    busy  = state_q == DIVBUSY;
    flush = hz.branch_taken | (state_q == BRFLUSH);
    stall = (lu | busy) & ~hz.branch_taken;
  end
  // Next state: a taken branch wins over everything and squashes any pending divide
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.branch_taken) begin
      state_d = (BRANCH_SLOTS > 1) ? BRFLUSH : IDLE;
      cnt_d   = BR_INIT;
    end else if (state_q != IDLE) begin
      state_d = (cnt_q == 5'd0) ? IDLE : state_q;
      cnt_d   = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
    end else if (hz.id_div & ~lu) begin
      state_d = DIVBUSY;
      cnt_d   = DIV_INIT;
    end
  end
  // State and slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign hz.hazard       = lu | busy;
  assign hz.BranchBubble = flush;
  assign hz.ifid_flush   = flush;
  assign hz.pc_stall     = stall;
  assign hz.ifid_stall   = stall;
  assign hz.div_busy     = busy;
  assign hz.fwdA         = fwd_sel(hz.ex_ra, hz.mem_rw, hz.mem_regWr, hz.wb_rw, hz.wb_regWr);
  assign hz.fwdB         = fwd_sel(hz.ex_rb, hz.mem_rw, hz.mem_regWr, hz.wb_rw, hz.wb_regWr);
`ifdef HAZ_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d, stat_bubble_q, stat_bubble_d;
  // Saturating event counters
  always_comb begin
    stat_stall_d  = (stall & ~&stat_stall_q) ? stat_stall_q + 32'd1 : stat_stall_q;
    stat_bubble_d = (flush & ~&stat_bubble_q) ? stat_bubble_q + 32'd1 : stat_bubble_q;
  end
  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q  <= 32'd0;
      stat_bubble_q <= 32'd0;
    end else begin
      stat_stall_q  <= stat_stall_d;
      stat_bubble_q <= stat_bubble_d;
    end
  end
  assign hz.stat_stall  = stat_stall_q;
  assign hz.stat_bubble = stat_bubble_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios for hazard_ctrl with BRANCH_SLOTS=3, DIV_CYCLES=8
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [5:0] outs;
  logic [5:0] exp_o;
  hazard_if hz();
  hazard_ctrl #(.BRANCH_SLOTS(3), .DIV_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  always #5 clk = ~clk;
  // {hazard, BranchBubble, ifid_flush, pc_stall, ifid_stall, div_busy}
  assign outs = {hz.hazard, hz.BranchBubble, hz.ifid_flush, hz.pc_stall, hz.ifid_stall, hz.div_busy};

  task automatic clr;
    hz.id_ra = 0; hz.id_rb = 0; hz.id_usesA = 0; hz.id_usesB = 0; hz.id_div = 0;
    hz.ex_ra = 0; hz.ex_rb = 0; hz.ex_rw = 0; hz.ex_regWr = 0; hz.ex_memtoreg = 0;
    hz.branch_taken = 0; hz.mem_rw = 0; hz.mem_regWr = 0; hz.wb_rw = 0; hz.wb_regWr = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic on);
    hz.ex_memtoreg = on; hz.ex_regWr = on; hz.ex_rw = on ? 5'd5 : 5'd0;
    hz.id_ra = 5'd5; hz.id_usesA = on;
  endtask

  task automatic test_reset;
    clr;
    rst_n = 1'b0;
    #12;
    checks++;
    if (outs !== 6'b0 || hz.fwdA !== 2'b00 || hz.fwdB !== 2'b00) begin
      errors++;
      $display("FAIL reset: outs=%b fwdA=%b fwdB=%b expected 000000/00/00", outs, hz.fwdA, hz.fwdB);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use;
    tick; clr; set_lu(1'b1); #1;
    exp_o = 6'b100110; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL lu_a: outs=%b expected=%b", outs, exp_o); end
    tick; clr; #1;
    exp_o = 6'b000000; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL lu_one_cycle: outs=%b expected=%b", outs, exp_o); end
    hz.ex_memtoreg = 1; hz.ex_regWr = 1; hz.ex_rw = 5'd9; hz.id_rb = 5'd9; hz.id_usesB = 1; #1;
    exp_o = 6'b100110; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL lu_b: outs=%b expected=%b", outs, exp_o); end
    hz.id_usesB = 0; #1;
    exp_o = 6'b000000; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL lu_unused: outs=%b expected=%b", outs, exp_o); end
    clr; hz.ex_memtoreg = 1; hz.ex_regWr = 1; hz.ex_rw = 0; hz.id_ra = 0; hz.id_usesA = 1; #1;
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL lu_r0: outs=%b expected=000000", outs); end
    hz.ex_rw = 5'd5; hz.id_ra = 5'd5; hz.ex_memtoreg = 0; #1;
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL lu_notload: outs=%b expected=000000", outs); end
  endtask

  task automatic test_branch;
    tick; clr; set_lu(1'b1); hz.branch_taken = 1; #1;
    exp_o = 6'b111000; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL br_n: outs=%b expected=%b", outs, exp_o); end
    for (int i = 1; i < 3; i++) begin
      tick; hz.branch_taken = 0; #1;
      exp_o = 6'b011000; checks++;
      if (outs !== exp_o) begin errors++; $display("FAIL br_slot%0d: outs=%b expected=%b", i, outs, exp_o); end
    end
    tick; #1;
    exp_o = 6'b100110; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL br_end: outs=%b expected=%b", outs, exp_o); end
    clr;
  endtask

  task automatic test_div;
    tick; clr; hz.id_div = 1; set_lu(1'b1); #1;
    tick; #1;
    exp_o = 6'b100110; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL div_lu_wait: outs=%b expected=%b", outs, exp_o); end
    set_lu(1'b0); #1;
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL div_pre: outs=%b expected=000000", outs); end
    tick; hz.id_div = 0; #1;
    for (int i = 0; i < 7; i++) begin
      exp_o = 6'b100111; checks++;
      if (outs !== exp_o) begin errors++; $display("FAIL div_hold%0d: outs=%b expected=%b", i, outs, exp_o); end
      tick; #1;
    end
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL div_done: outs=%b expected=000000", outs); end
  endtask

  task automatic test_div_branch;
    tick; clr; hz.id_div = 1; hz.branch_taken = 1; #1;
    exp_o = 6'b011000; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL divbr_n: outs=%b expected=%b", outs, exp_o); end
    tick; clr; #1;
    checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL divbr_nodiv: outs=%b expected=%b", outs, exp_o); end
    tick; tick; #1;
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL divbr_end: outs=%b expected=000000", outs); end
    hz.id_div = 1; tick; hz.id_div = 0; tick; hz.branch_taken = 1; #1;
    exp_o = 6'b111001; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL div_then_br: outs=%b expected=%b", outs, exp_o); end
    tick; hz.branch_taken = 0; #1;
    exp_o = 6'b011000; checks++;
    if (outs !== exp_o) begin errors++; $display("FAIL div_br_abort: outs=%b expected=%b", outs, exp_o); end
    tick; tick; #1;
  endtask

  task automatic test_fwd;
    clr; hz.ex_ra = 7; hz.ex_rb = 7; hz.mem_rw = 7; hz.mem_regWr = 1; hz.wb_rw = 7; hz.wb_regWr = 1; #1;
    checks++;
    if (hz.fwdA !== 2'b10 || hz.fwdB !== 2'b10) begin
      errors++; $display("FAIL fwd_mem: fwdA=%b fwdB=%b expected 10/10", hz.fwdA, hz.fwdB);
    end
    hz.mem_regWr = 0; #1;
    checks++;
    if (hz.fwdA !== 2'b01) begin errors++; $display("FAIL fwd_wb: fwdA=%b expected=01", hz.fwdA); end
    hz.mem_regWr = 1; hz.mem_rw = 3; #1;
    checks++;
    if (hz.fwdA !== 2'b01) begin errors++; $display("FAIL fwd_wb_mismatch: fwdA=%b expected=01", hz.fwdA); end
    hz.ex_rb = 3; #1;
    checks++;
    if (hz.fwdB !== 2'b10) begin errors++; $display("FAIL fwdB_mem: fwdB=%b expected=10", hz.fwdB); end
    hz.ex_rb = 0; hz.mem_rw = 0; hz.wb_rw = 0; #1;
    checks++;
    if (hz.fwdB !== 2'b00) begin errors++; $display("FAIL fwd_r0: fwdB=%b expected=00", hz.fwdB); end
    hz.ex_ra = 7; hz.wb_rw = 7; hz.wb_regWr = 0; #1;
    checks++;
    if (hz.fwdA !== 2'b00) begin errors++; $display("FAIL fwd_none: fwdA=%b expected=00", hz.fwdA); end
    clr;
  endtask

  task automatic test_reset_mid_div;
    tick; clr; hz.id_div = 1; tick; hz.id_div = 0; tick; tick; #1;
    checks++;
    if (outs !== 6'b100111) begin errors++; $display("FAIL rst_pre: outs=%b expected=100111", outs); end
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL rst_async: outs=%b expected=000000", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    tick; hz.id_div = 1; tick; hz.id_div = 0; #1;
    for (int i = 0; i < 7; i++) begin
      exp_o = 6'b100111; checks++;
      if (outs !== exp_o) begin errors++; $display("FAIL rst_hold%0d: outs=%b expected=%b", i, outs, exp_o); end
      tick; #1;
    end
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL rst_done: outs=%b expected=000000", outs); end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_div;
    test_div_branch;
    test_fwd;
    test_reset_mid_div;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
